// File: rtl/msg_request_queue_if.sv
// Request/dispatch bundle between session_manager, the request queue and
// the create-message builder. The queue uses the slave side; the requester
// and builder (or a bench) use the master side.
interface msg_request_queue_if #(
  parameter int VALUE_WIDTH = 32,
  parameter int SIZE        = 8,
  parameter int DEPTH       = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   req_valid_i;
  logic [3:0]             req_type_i;
  logic [VALUE_WIDTH-1:0] req_target_i;
  logic [SIZE-1:0]        req_size_i;
  logic                   builder_busy_i;

  logic                   start_o;
  logic [3:0]             msg_type_o;
  logic [VALUE_WIDTH-1:0] target_o;
  logic [SIZE-1:0]        size_o;
  logic [CW-1:0]          count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   overflow_o;
  logic                   coalesced_o;
  logic                   ack_err_o;

  modport master (
    output req_valid_i, req_type_i, req_target_i, req_size_i, builder_busy_i,
    input  start_o, msg_type_o, target_o, size_o, count_o,
           full_o, empty_o, overflow_o, coalesced_o, ack_err_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_target_i, req_size_i, builder_busy_i,
    output start_o, msg_type_o, target_o, size_o, count_o,
           full_o, empty_o, overflow_o, coalesced_o, ack_err_o
  );
endinterface

// File: rtl/msg_request_queue.sv
// Create-message request queue: buffers requests from session_manager in a
// circular FIFO, merges repeated heartbeats to the same target, and hands
// entries one at a time to the builder with a start/busy handshake.
module msg_request_queue #(
  parameter int         VALUE_WIDTH    = 32,
  parameter int         SIZE           = 8,
  parameter int         DEPTH          = 8,
  parameter int         ACK_TIMEOUT    = 16,
  parameter logic [3:0] TYPE_HEARTBEAT = 4'h3
) (
  input  logic                 clk,
  input  logic                 rst,
  msg_request_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int EW = 4 + SIZE + VALUE_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [EW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_full;
  logic                   r_empty;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_nxt;
  logic                   r_start;
  logic                   r_overflow;
  logic                   r_coalesced;
  logic                   r_ack_err;
  logic [3:0]             r_msg_type;
  logic [VALUE_WIDTH-1:0] r_target;
  logic [SIZE-1:0]        r_size;

  logic                   w_pop;
  logic                   w_push;
  logic                   w_coalesce;
  logic                   w_drop;
  logic                   w_ack_err;
  logic [EW-1:0]          w_tail;
  logic [EW-1:0]          w_head;
  logic [CW-1:0]          w_count_nxt;

  // Entry layout is {type, size, target}; the tail is the newest entry.
  assign w_tail = r_mem[r_wr_ptr - AW'(1)];
  assign w_head = r_mem[r_rd_ptr];

  // Dispatch FSM next-state: one message in flight, waiting for busy then idle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    w_ack_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && !bus.builder_busy_i) begin
          w_pop       = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (bus.builder_busy_i) begin
          w_state_nxt = S_DONE;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          // Builder ignored the start; the message is dropped, not retried.
          w_ack_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_DONE: begin
        if (!bus.builder_busy_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request admission: coalesce first, then accept if room (a same-cycle pop frees a slot).
  always_comb begin
    w_coalesce = bus.req_valid_i && (bus.req_type_i == TYPE_HEARTBEAT) && !r_empty &&
                 (w_tail[EW-1 -: 4] == TYPE_HEARTBEAT) &&
                 (w_tail[VALUE_WIDTH-1:0] == bus.req_target_i);
    w_push      = bus.req_valid_i && !w_coalesce && (!r_full || w_pop);
    w_drop      = bus.req_valid_i && !w_coalesce && r_full && !w_pop;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Queue storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_type_i, bus.req_size_i, bus.req_target_i};
    end
  end

  // Pointers, occupancy, FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_timer     <= '0;
      r_start     <= 1'b0;
      r_overflow  <= 1'b0;
      r_coalesced <= 1'b0;
      r_ack_err   <= 1'b0;
      r_msg_type  <= 4'h0;
      r_target    <= '0;
      r_size      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_empty     <= (w_count_nxt == CW'(0));
      r_start     <= w_pop;
      r_overflow  <= w_drop;
      r_coalesced <= w_coalesce;
      r_ack_err   <= w_ack_err;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_msg_type <= w_head[EW-1 -: 4];
        r_size     <= w_head[VALUE_WIDTH +: SIZE];
        r_target   <= w_head[VALUE_WIDTH-1:0];
      end
    end
  end

  assign bus.start_o     = r_start;
  assign bus.msg_type_o  = r_msg_type;
  assign bus.target_o    = r_target;
  assign bus.size_o      = r_size;
  assign bus.count_o     = r_count;
  assign bus.full_o      = r_full;
  assign bus.empty_o     = r_empty;
  assign bus.overflow_o  = r_overflow;
  assign bus.coalesced_o = r_coalesced;
  assign bus.ack_err_o   = r_ack_err;
endmodule

// File: tb/tb_msg_request_queue.sv
// Bench for msg_request_queue: directed sequences, a coalescing vector table
// and a long randomized run, all compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_msg_request_queue;
  localparam int VW = 32;
  localparam int SW = 8;
  localparam int DEPTH = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] T_LOGON  = 4'h1;
  localparam logic [3:0] T_LOGOUT = 4'h2;
  localparam logic [3:0] T_HB     = 4'h3;
  localparam logic [3:0] T_RESEND = 4'h4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_request_queue_if #(.VALUE_WIDTH(VW), .SIZE(SW), .DEPTH(DEPTH)) bus();

  msg_request_queue #(
    .VALUE_WIDTH(VW), .SIZE(SW), .DEPTH(DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT), .TYPE_HEARTBEAT(T_HB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending entries as a queue, dispatcher as a phase.
  typedef struct { logic [3:0] t; logic [VW-1:0] tg; logic [SW-1:0] sz; } ent_t;
  ent_t mq[$];
  int   m_phase;   // 0 free, 1 waiting for builder busy, 2 builder building
  int   m_wait;
  logic e_start, e_ovf, e_coal, e_err;
  logic [3:0]    e_type;
  logic [VW-1:0] e_tg;
  logic [SW-1:0] e_sz;

  typedef struct {
    logic rv; logic [3:0] t; logic [VW-1:0] tg; logic [CW-1:0] cnt; logic coal;
  } vec_t;
  vec_t tbl[7];

  int seen_tg[$];
  int start_idx[$];
  int err_idx[$];
  int cur_dly, cur_len;
  bit resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_wait = 0;
    e_start = 1'b0; e_ovf = 1'b0; e_coal = 1'b0; e_err = 1'b0;
    e_type = 4'h0; e_tg = '0; e_sz = '0;
  endtask

  task automatic model_step(input logic rv, input logic [3:0] t, input logic [VW-1:0] tg,
                            input logic [SW-1:0] sz, input logic busy);
    bit pop, coal;
    ent_t h, n;
    e_start = 1'b0; e_ovf = 1'b0; e_coal = 1'b0; e_err = 1'b0;
    pop = 1'b0;
    if (m_phase == 0) begin
      pop = (mq.size() > 0) && !busy;
    end else if (m_phase == 1) begin
      if (busy) m_phase = 2;
      else begin
        m_wait++;
        if (m_wait == ACK_TIMEOUT) begin e_err = 1'b1; m_phase = 0; end
      end
    end else begin
      if (!busy) m_phase = 0;
    end
    coal = rv && (t == T_HB) && (mq.size() > 0) && (mq[$].t == T_HB) && (mq[$].tg == tg);
    if (pop) begin
      h = mq.pop_front();
      e_start = 1'b1; e_type = h.t; e_tg = h.tg; e_sz = h.sz;
      m_phase = 1; m_wait = 0;
    end
    if (coal) e_coal = 1'b1;
    else if (rv) begin
      if (mq.size() < DEPTH) begin n.t = t; n.tg = tg; n.sz = sz; mq.push_back(n); end
      else e_ovf = 1'b1;
    end
  endtask

  task automatic compare_model();
    check("start_o",     bus.start_o,     e_start);
    check("count_o",     bus.count_o,     mq.size());
    check("full_o",      bus.full_o,      mq.size() == DEPTH);
    check("empty_o",     bus.empty_o,     mq.size() == 0);
    check("overflow_o",  bus.overflow_o,  e_ovf);
    check("coalesced_o", bus.coalesced_o, e_coal);
    check("ack_err_o",   bus.ack_err_o,   e_err);
    check("msg_type_o",  bus.msg_type_o,  e_type);
    check("target_o",    bus.target_o,    e_tg);
    check("size_o",      bus.size_o,      e_sz);
  endtask

  task automatic cycle(input logic rv, input logic [3:0] t, input logic [VW-1:0] tg,
                       input logic [SW-1:0] sz, input logic busy);
    bus.req_valid_i    = rv;
    bus.req_type_i     = t;
    bus.req_target_i   = tg;
    bus.req_size_i     = sz;
    bus.builder_busy_i = busy;
    model_step(rv, t, tg, sz, busy);
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_type_i = 4'h0; bus.req_target_i = '0;
    bus.req_size_i = '0; bus.builder_busy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Runs n cycles with a builder that answers each start_o after dly cycles for len cycles.
  task automatic run(input int n, input int dly, input int len, input bit respond, input bit rnd);
    int bd_wait, bd_left;
    logic bz, rv;
    logic [3:0] t;
    logic [VW-1:0] tg;
    bd_wait = -1; bd_left = 0;
    cur_dly = dly; cur_len = len; resp = respond;
    seen_tg.delete(); start_idx.delete(); err_idx.delete();
    for (int i = 0; i < n; i++) begin
      if (bd_left > 0) begin bz = 1'b1; bd_left--; end
      else if (bd_wait == 0) begin bz = 1'b1; bd_left = cur_len - 1; bd_wait = -1; end
      else begin
        bz = rnd && ($urandom_range(0, 15) == 0);
        if (bd_wait > 0) bd_wait--;
      end
      rv = 1'b0; t = 4'h0; tg = '0;
      if (rnd && ($urandom_range(0, 1) == 1)) begin
        rv = 1'b1;
        t  = 4'($urandom_range(1, 4));
        tg = VW'(32'h41) + VW'($urandom_range(0, 2));
      end
      cycle(rv, t, tg, SW'($urandom_range(1, 3)), bz);
      if (bus.start_o) begin
        seen_tg.push_back(int'(bus.target_o));
        start_idx.push_back(i);
        if (rnd) begin
          cur_dly = $urandom_range(0, 2);
          cur_len = $urandom_range(1, 4);
          resp = ($urandom_range(0, 7) != 0);
        end
        if (resp) bd_wait = cur_dly;
      end
      if (bus.ack_err_o) err_idx.push_back(i);
    end
  endtask

  initial begin
    int ns;
    model_reset();

    // Reset state.
    do_reset();
    check("rst_start",    bus.start_o,     1'b0);
    check("rst_count",    bus.count_o,     0);
    check("rst_empty",    bus.empty_o,     1'b1);
    check("rst_full",     bus.full_o,      1'b0);
    check("rst_overflow", bus.overflow_o,  1'b0);
    check("rst_coalesce", bus.coalesced_o, 1'b0);
    check("rst_ack_err",  bus.ack_err_o,   1'b0);
    check("rst_target",   bus.target_o,    0);

    // Single logon with the two-edge dispatch latency.
    cycle(1'b1, T_LOGON, 32'h41, 8'd1, 1'b0);
    check("t2_no_early_start", bus.start_o, 1'b0);
    run(20, 1, 5, 1'b1, 1'b0);
    check("t2_num_starts", seen_tg.size(), 1);
    if (seen_tg.size() > 0) begin
      check("t2_latency", start_idx[0], 0);
      check("t2_target",  seen_tg[0], 32'h41);
    end
    check("t2_type_held",  bus.msg_type_o, T_LOGON);
    check("t2_count_zero", bus.count_o, 0);

    // Fill past DEPTH while busy, then drain in FIFO order.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, T_LOGOUT, VW'(32'h10 + i), 8'd2, 1'b1);
      if (i == 7) check("t3_full_after_8", bus.full_o, 1'b1);
    end
    check("t3_overflow_9th", bus.overflow_o, 1'b1);
    run(60, 1, 2, 1'b1, 1'b0);
    check("t3_num_starts", seen_tg.size(), 8);
    for (int k = 0; k < seen_tg.size() && k < 8; k++) check("t3_fifo_order", seen_tg[k], 32'h10 + k);

    // Heartbeat coalescing table (builder held busy).
    do_reset();
    tbl[0] = '{1'b1, T_HB,    32'h41, 4'd1, 1'b0};
    tbl[1] = '{1'b1, T_HB,    32'h41, 4'd1, 1'b1};
    tbl[2] = '{1'b1, T_HB,    32'h42, 4'd2, 1'b0};
    tbl[3] = '{1'b1, T_HB,    32'h42, 4'd2, 1'b1};
    tbl[4] = '{1'b1, T_HB,    32'h41, 4'd3, 1'b0};
    tbl[5] = '{1'b1, T_LOGON, 32'h41, 4'd4, 1'b0};
    tbl[6] = '{1'b1, T_HB,    32'h41, 4'd5, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].rv, tbl[i].t, tbl[i].tg, 8'd1, 1'b1);
      check("t4_count", bus.count_o, tbl[i].cnt);
      check("t4_coalesced", bus.coalesced_o, tbl[i].coal);
    end

    // Builder never goes busy: timeout, then the next entry is dispatched.
    do_reset();
    cycle(1'b1, T_LOGON, 32'h51, 8'd1, 1'b0);
    cycle(1'b1, T_LOGON, 32'h52, 8'd1, 1'b0);
    check("t5_first_start", bus.start_o, 1'b1);
    run(40, 0, 1, 1'b0, 1'b0);
    check("t5_num_errs", err_idx.size(), 2);
    if (err_idx.size() > 0) check("t5_err_timing", err_idx[0], 15);
    check("t5_num_starts", seen_tg.size(), 1);
    if (seen_tg.size() > 0) begin
      check("t5_next_start_timing", start_idx[0], 16);
      check("t5_next_target", seen_tg[0], 32'h52);
    end

    // Full queue with simultaneous push and pop, then reset during ACK.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, T_LOGOUT, VW'(32'h20 + i), 8'd2, 1'b1);
    check("t6_full", bus.full_o, 1'b1);
    cycle(1'b1, T_RESEND, 32'h99, 8'd3, 1'b0);
    check("t6_count_stays", bus.count_o, 8);
    check("t6_no_overflow", bus.overflow_o, 1'b0);
    check("t6_start", bus.start_o, 1'b1);
    check("t6_head_target", bus.target_o, 32'h20);
    cycle(1'b0, 4'h0, '0, '0, 1'b0);
    do_reset();
    ns = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(1'b0, 4'h0, '0, '0, 1'b0);
      if (bus.start_o) ns++;
    end
    check("t6_no_start_after_rst", ns, 0);
    check("t6_empty_after_rst", bus.empty_o, 1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    run(3000, 1, 2, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
